// File: rtl/census_pkg.sv
// rtl/census_pkg.sv - shared widths, constants and helpers for census disparity blocks
package census_pkg;

    localparam int CENSUS_W = 16;
    localparam int COST_W   = 4;
    localparam logic [COST_W-1:0] COST_MASKED = 4'd15;

    localparam int DEFAULT_MAX_DISP = 16;

    function automatic int disp_width(input int max_disp);
        return (max_disp <= 2) ? 1 : $clog2(max_disp);
    endfunction

    localparam int DISP_W = disp_width(DEFAULT_MAX_DISP);

    function automatic logic [COST_W-1:0] popcount8(input logic [7:0] x);
        logic [COST_W-1:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {{(COST_W-1){1'b0}}, x[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/census_wta_tree.sv
// rtl/census_wta_tree.sv - registered min/argmin reduction, smaller index wins ties
module census_wta_tree
    import census_pkg::*;
#(
    parameter int N     = DEFAULT_MAX_DISP,
    parameter int IDX_W = DISP_W,
    parameter int CW    = COST_W,
    parameter int TAG_W = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               valid_i,
    input  logic [N*CW-1:0]    costs_i,
    input  logic [TAG_W-1:0]   tag_i,
    output logic               valid_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic [CW-1:0]      cost_o,
    output logic [TAG_W-1:0]   tag_o
);

    // Heap layout: leaves at N-1..2N-2, node i reduces children 2i+1 (lower indices) and 2i+2.
    logic [CW-1:0]    node_cost [2*N-1];
    logic [IDX_W-1:0] node_idx  [2*N-1];

    logic             valid_q;
    logic [IDX_W-1:0] idx_q;
    logic [CW-1:0]    cost_q;
    logic [TAG_W-1:0] tag_q;

    always_comb begin
        for (int i = 0; i < 2*N-1; i++) begin
            node_cost[i] = '0;
            node_idx[i]  = '0;
        end
        for (int i = 0; i < N; i++) begin
            node_cost[N-1+i] = costs_i[i*CW +: CW];
            node_idx[N-1+i]  = IDX_W'(i);
        end
        // Strict less-than keeps the left (smaller-index) child on a tie.
        for (int i = N-2; i >= 0; i--) begin
            if (node_cost[2*i+2] < node_cost[2*i+1]) begin
                node_cost[i] = node_cost[2*i+2];
                node_idx[i]  = node_idx[2*i+2];
            end else begin
                node_cost[i] = node_cost[2*i+1];
                node_idx[i]  = node_idx[2*i+1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            cost_q  <= '0;
            tag_q   <= '0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                idx_q  <= node_idx[0];
                cost_q <= node_cost[0];
                tag_q  <= tag_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign idx_o   = idx_q;
    assign cost_o  = cost_q;
    assign tag_o   = tag_q;

endmodule

// File: rtl/census_wta_disparity.sv
// rtl/census_wta_disparity.sv - census Hamming-cost winner-take-all disparity stream
module census_wta_disparity
    import census_pkg::*;
#(
    parameter int IMAGE_WIDTH  = 320,
    parameter int IMAGE_HEIGHT = 240,
    parameter int MAX_DISP     = 16,
    parameter int CODE_BITS    = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        census_valid,
    input  logic [CENSUS_W-1:0]         census_l,
    input  logic [CENSUS_W-1:0]         census_r,
    output logic                        disp_valid,
    output logic [$clog2(MAX_DISP)-1:0] disp_out,
    output logic [COST_W-1:0]           cost_out,
    output logic [15:0]                 disp_row,
    output logic [15:0]                 disp_col
);

    localparam int DW = $clog2(MAX_DISP);
    localparam logic [7:0] CODE_MASK = 8'((1 << CODE_BITS) - 1);

    logic unused_upper_bits;
    assign unused_upper_bits = ^{census_l[CENSUS_W-1:8], census_r[CENSUS_W-1:8]};

    logic [15:0] col_q, col_d;
    logic [15:0] row_q, row_d;

    logic [7:0]  hist_q [MAX_DISP];
    logic [7:0]  l0_q;
    logic [15:0] col0_q, row0_q;
    logic        v0_q;

    logic [MAX_DISP*COST_W-1:0] cost_d, cost1_q;
    logic [15:0] col1_q, row1_q;
    logic        v1_q;

    logic [31:0] tag_out;

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (census_valid) begin
            if (col_q == 16'(IMAGE_WIDTH - 1)) begin
                col_d = '0;
                row_d = (row_q == 16'(IMAGE_HEIGHT - 1)) ? '0 : row_q + 16'd1;
            end else begin
                col_d = col_q + 16'd1;
            end
        end
    end

    // Stage 0: history slot h[d] ends up holding the right code at col-d.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q  <= '0;
            row_q  <= '0;
            l0_q   <= '0;
            col0_q <= '0;
            row0_q <= '0;
            v0_q   <= 1'b0;
            for (int k = 0; k < MAX_DISP; k++) begin
                hist_q[k] <= '0;
            end
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            v0_q  <= census_valid;
            if (census_valid) begin
                l0_q      <= census_l[7:0];
                col0_q    <= col_q;
                row0_q    <= row_q;
                hist_q[0] <= census_r[7:0];
                for (int k = 1; k < MAX_DISP; k++) begin
                    hist_q[k] <= hist_q[k-1];
                end
            end
        end
    end

    // Candidates reaching past column 0 would read the previous row; force them to lose.
    always_comb begin
        cost_d = '0;
        for (int d = 0; d < MAX_DISP; d++) begin
            if (d <= int'(col0_q)) begin
                cost_d[d*COST_W +: COST_W] = popcount8((l0_q ^ hist_q[d]) & CODE_MASK);
            end else begin
                cost_d[d*COST_W +: COST_W] = COST_MASKED;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cost1_q <= '0;
            col1_q  <= '0;
            row1_q  <= '0;
            v1_q    <= 1'b0;
        end else begin
            v1_q <= v0_q;
            if (v0_q) begin
                cost1_q <= cost_d;
                col1_q  <= col0_q;
                row1_q  <= row0_q;
            end
        end
    end

    census_wta_tree #(
        .N     (MAX_DISP),
        .IDX_W (DW),
        .CW    (COST_W),
        .TAG_W (32)
    ) u_wta_tree (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid_i (v1_q),
        .costs_i (cost1_q),
        .tag_i   ({row1_q, col1_q}),
        .valid_o (disp_valid),
        .idx_o   (disp_out),
        .cost_o  (cost_out),
        .tag_o   (tag_out)
    );

    assign disp_row = tag_out[31:16];
    assign disp_col = tag_out[15:0];

endmodule

// File: tb/tb_census_wta_disparity.sv
// tb/tb_census_wta_disparity.sv - randomized directed bench with behavioural disparity model
module tb_census_wta_disparity;

    localparam int W  = 32;
    localparam int H  = 8;
    localparam int MD = 8;

    typedef struct {
        bit v;
        int d;
        int c;
        int row;
        int col;
    } res_t;

    logic        clk;
    logic        rst_n;
    logic        census_valid;
    logic [15:0] census_l;
    logic [15:0] census_r;
    logic        disp_valid;
    logic [2:0]  disp_out;
    logic [3:0]  cost_out;
    logic [15:0] disp_row;
    logic [15:0] disp_col;

    census_wta_disparity #(
        .IMAGE_WIDTH  (W),
        .IMAGE_HEIGHT (H),
        .MAX_DISP     (MD),
        .CODE_BITS    (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .census_valid (census_valid),
        .census_l     (census_l),
        .census_r     (census_r),
        .disp_valid   (disp_valid),
        .disp_out     (disp_out),
        .cost_out     (cost_out),
        .disp_row     (disp_row),
        .disp_col     (disp_col)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_total, n_pass, n_fail, dut_pulses;
    int   m_col, m_row;
    logic [7:0] rrow_m [W];
    res_t p0, p1, held;
    logic [7:0] lrow [W];
    logic [7:0] rrow [W];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        p0 = '{0, 0, 0, 0, 0};
        p1 = '{0, 0, 0, 0, 0};
        held = '{0, 0, 0, 0, 0};
        m_col = 0;
        m_row = 0;
    endtask

    function automatic logic [15:0] upper_noise(input logic [7:0] code);
        logic [7:0] hi;
        hi = 8'($urandom);
        return {hi, code};
    endfunction

    // Drive one cycle, advance the model on the edge, then compare #1 after the edge.
    task automatic step(input logic v, input logic [7:0] l, input logic [7:0] r);
        res_t nw, outv;
        int bc, bd, c;
        census_valid = v;
        census_l = upper_noise(l);
        census_r = upper_noise(r);
        @(posedge clk);
        nw = '{0, 0, 0, 0, 0};
        if (v) begin
            rrow_m[m_col] = r;
            bc = 99;
            bd = 0;
            for (int d = 0; d < MD; d++) begin
                if (d <= m_col) begin
                    c = $countones(l ^ rrow_m[m_col - d]);
                    if (c < bc) begin
                        bc = c;
                        bd = d;
                    end
                end
            end
            nw = '{1, bd, bc, m_row, m_col};
            m_col++;
            if (m_col == W) begin
                m_col = 0;
                m_row = (m_row + 1) % H;
            end
        end
        outv = p1;
        p1 = p0;
        p0 = nw;
        #1;
        if (outv.v) held = outv;
        if (disp_valid) dut_pulses++;
        chk("disp_valid", 32'(disp_valid), 32'(outv.v));
        chk("disp_out", 32'(disp_out), held.d);
        chk("cost_out", 32'(cost_out), held.c);
        chk("disp_row", 32'(disp_row), held.row);
        chk("disp_col", 32'(disp_col), held.col);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_valid"}, 32'(disp_valid), 0);
        chk({tag, "_disp"}, 32'(disp_out), 0);
        chk({tag, "_cost"}, 32'(cost_out), 0);
        chk({tag, "_row"}, 32'(disp_row), 0);
        chk({tag, "_col"}, 32'(disp_col), 0);
    endtask

    initial begin
        logic [7:0] base;
        n_total = 0;
        n_pass = 0;
        n_fail = 0;
        dut_pulses = 0;
        rst_n = 1'b0;
        census_valid = 1'b0;
        census_l = '0;
        census_r = '0;
        for (int i = 0; i < W; i++) rrow_m[i] = '0;
        model_reset();

        repeat (2) @(posedge clk);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;

        // Identical streams: zero cost at disparity 0 everywhere.
        for (int c = 0; c < W; c++) step(1'b1, 8'h5A, 8'h5A);
        step(1'b0, 8'h00, 8'h00);
        step(1'b0, 8'h00, 8'h00);

        // Right stream is the left delayed by 5 columns, unique codes per column.
        base = 8'($urandom);
        for (int c = 0; c < W; c++) lrow[c] = 8'(c * 37) + base;
        for (int c = 0; c < W; c++) rrow[c] = (c >= 5) ? lrow[c - 5] : 8'($urandom);
        for (int c = 0; c < W; c++) step(1'b1, lrow[c], rrow[c]);
        step(1'b0, 8'h00, 8'h00);
        step(1'b0, 8'h00, 8'h00);

        // Same row with valid every third cycle.
        dut_pulses = 0;
        for (int c = 0; c < W; c++) begin
            step(1'b1, lrow[c], rrow[c]);
            step(1'b0, 8'h00, 8'h00);
            step(1'b0, 8'h00, 8'h00);
        end
        chk("gap_pulses", dut_pulses, W);

        // Tie between d=2 and d=6 at column 7, smaller disparity must win.
        for (int c = 0; c < W; c++) begin
            step(1'b1, (c == 7) ? 8'h0F : 8'($urandom),
                 (c == 1 || c == 5) ? 8'h0F : 8'hF0);
        end

        // First pixel of the next row must not see the previous row's history.
        step(1'b1, 8'hFF, 8'h00);

        // Two results in flight when reset hits.
        step(1'b1, 8'($urandom), 8'($urandom));
        step(1'b1, 8'($urandom), 8'($urandom));
        rst_n = 1'b0;
        #1;
        chk_zero("async_reset");
        model_reset();
        step(1'b0, 8'h00, 8'h00);
        rst_n = 1'b1;
        step(1'b0, 8'h00, 8'h00);
        step(1'b0, 8'h00, 8'h00);
        for (int c = 0; c < 4; c++) step(1'b1, 8'($urandom), 8'($urandom));
        step(1'b0, 8'h00, 8'h00);
        step(1'b0, 8'h00, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
